// File: rtl/mips_cpu_mem_pkg.sv
// Shared types and constants for the MIPS CPU memory arbiter.
package mips_cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  localparam int         DATA_STREAK_MAX_DEFAULT = 4;
  localparam logic [3:0] BE_ALL                  = 4'b1111;

endpackage

// File: rtl/mips_cpu_mem_arb_pick.sv
// Combinational grant decision between instruction fetch and data access.
module mips_cpu_mem_arb_pick
  import mips_cpu_mem_pkg::*;
#(
  parameter int DATA_STREAK_MAX = DATA_STREAK_MAX_DEFAULT,
  parameter int STREAK_W        = $clog2(DATA_STREAK_MAX + 1)
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_i,
  output logic                grant_d
);

  logic starved;

  // Data wins ties until the fetch side has watched a full streak go by.
  assign starved = i_req && (streak == STREAK_W'(DATA_STREAK_MAX));

  always_comb begin
    grant_d = d_req && !starved;
    grant_i = i_req && !grant_d;
  end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data.
//
//   state     | meaning
//   ST_IDLE   | no transaction; pick a requester
//   ST_BUSY_I | fetch command on mem_*, waiting for !mem_waitrequest
//   ST_BUSY_D | load/store command on mem_*, waiting for !mem_waitrequest
//   ST_RESP   | one-cycle ack to the granted requester
module mips_cpu_mem_arbiter
  import mips_cpu_mem_pkg::*;
#(
  parameter int DATA_STREAK_MAX = DATA_STREAK_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_writedata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  localparam int STREAK_W = $clog2(DATA_STREAK_MAX + 1);

  arb_state_t          state, state_nx;
  logic [STREAK_W-1:0] streak;
  logic                grant_i, grant_d;
  logic [31:0]         lat_addr;
  logic [31:0]         lat_wdata;
  logic [3:0]          lat_be;
  logic                lat_write;
  logic                lat_is_d;
  logic                busy;

  mips_cpu_mem_arb_pick #(
    .DATA_STREAK_MAX (DATA_STREAK_MAX),
    .STREAK_W        (STREAK_W)
  ) u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
    .streak  (streak),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (grant_i)      state_nx = ST_BUSY_I;
        else if (grant_d) state_nx = ST_BUSY_D;
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (!mem_waitrequest) state_nx = ST_RESP;
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state == ST_BUSY_I) || (state == ST_BUSY_D);
    mem_read       = (state == ST_BUSY_I) || ((state == ST_BUSY_D) && !lat_write);
    mem_write      = (state == ST_BUSY_D) && lat_write;
    mem_address    = busy ? lat_addr  : '0;
    mem_byteenable = busy ? lat_be    : '0;
    mem_writedata  = busy ? lat_wdata : '0;
    i_ack          = (state == ST_RESP) && !lat_is_d;
    d_ack          = (state == ST_RESP) && lat_is_d;
  end

  // Command latch, streak tracking and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_write <= 1'b0;
      lat_is_d  <= 1'b0;
      streak    <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (grant_d) begin
          lat_addr  <= d_address;
          lat_wdata <= d_writedata;
          lat_be    <= d_byteenable;
          lat_write <= d_write;
          lat_is_d  <= 1'b1;
          if (i_req && (streak != STREAK_W'(DATA_STREAK_MAX)))
            streak <= streak + STREAK_W'(1);
        end else if (grant_i) begin
          lat_addr  <= i_address;
          lat_wdata <= '0;
          lat_be    <= BE_ALL;
          lat_write <= 1'b0;
          lat_is_d  <= 1'b0;
          streak    <= '0;
        end
      end
      if (!mem_waitrequest) begin
        if (state == ST_BUSY_I) i_rdata <= mem_readdata;
        if ((state == ST_BUSY_D) && !lat_write) d_rdata <= mem_readdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed-vector bench for mips_cpu_mem_arbiter with a scripted memory.
module tb_mips_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_write, i_ack, d_ack;
  logic [31:0] i_address, d_address, d_writedata, i_rdata, d_rdata;
  logic [3:0]  d_byteenable, mem_byteenable;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest;

  int n_vec = 0;
  int n_bad = 0;

  mips_cpu_mem_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_req           (i_req),
    .i_address       (i_address),
    .i_ack           (i_ack),
    .i_rdata         (i_rdata),
    .d_req           (d_req),
    .d_write         (d_write),
    .d_address       (d_address),
    .d_byteenable    (d_byteenable),
    .d_writedata     (d_writedata),
    .d_ack           (d_ack),
    .d_rdata         (d_rdata),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    int          waits;
    logic [31:0] rdata;
    logic        exp_d;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_rd, e_wr;
    e_addr = v.exp_d ? v.d_addr : v.i_addr;
    e_be   = v.exp_d ? v.d_be : 4'b1111;
    e_wr   = v.exp_d && v.d_write;
    e_rd   = !e_wr;
    i_req = v.i_req; i_address = v.i_addr;
    d_req = v.d_req; d_write = v.d_write; d_address = v.d_addr;
    d_byteenable = v.d_be; d_writedata = v.d_wdata;
    mem_readdata = v.rdata; mem_waitrequest = (v.waits > 0);
    @(posedge clk); #1;
    for (int k = 0; k <= v.waits; k++) begin
      mem_waitrequest = (k < v.waits);
      @(negedge clk);
      chk($sformatf("v%0d.c%0d mem_read", idx, k), 32'(mem_read), 32'(e_rd));
      chk($sformatf("v%0d.c%0d mem_write", idx, k), 32'(mem_write), 32'(e_wr));
      chk($sformatf("v%0d.c%0d mem_address", idx, k), mem_address, e_addr);
      chk($sformatf("v%0d.c%0d mem_byteenable", idx, k), 32'(mem_byteenable), 32'(e_be));
      if (e_wr) chk($sformatf("v%0d.c%0d mem_writedata", idx, k), mem_writedata, v.d_wdata);
      chk($sformatf("v%0d.c%0d acks_busy", idx, k), 32'({i_ack, d_ack}), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk($sformatf("v%0d acks_resp", idx), 32'({i_ack, d_ack}), v.exp_d ? 32'd1 : 32'd2);
    chk($sformatf("v%0d strobes_resp", idx), 32'({mem_read, mem_write}), 32'd0);
    chk($sformatf("v%0d i_rdata", idx), i_rdata, v.exp_i_rdata);
    chk($sformatf("v%0d d_rdata", idx), d_rdata, v.exp_d_rdata);
    i_req = 1'b0; d_req = 1'b0; mem_waitrequest = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("v%0d idle_after", idx), 32'({i_ack, d_ack, mem_read, mem_write}), 32'd0);
  endtask

  initial begin
    int  ack_cyc[$];
    logic ack_is_i[$];
    int  overlap;
    int  n_rd, n_dack, n_iack, n_str;

    vecs[0] = '{1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0,
                32'h2402_0005, 1'b0, 32'h2402_0005, 32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'hAAAA_5555, 1,
                32'h1234_5678, 1'b1, 32'h2402_0005, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1000, 4'h3, 32'hDEAD_BEEF, 3,
                32'hFFFF_FFFF, 1'b1, 32'h2402_0005, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2,
                32'h8C82_0004, 1'b0, 32'h8C82_0004, 32'h1234_5678};
    vecs[4] = '{1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h0000_3000, 4'h4, 32'h0, 0,
                32'h0000_00AB, 1'b1, 32'h8C82_0004, 32'h0000_00AB};
    vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3004, 4'hC, 32'h0102_0304, 1,
                32'h0, 1'b1, 32'h8C82_0004, 32'h0000_00AB};
    vecs[6] = '{1'b1, 32'h0040_0008, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0,
                32'h27BD_FFE8, 1'b0, 32'h27BD_FFE8, 32'h0000_00AB};

    reset_n = 1'b0;
    i_req = 1'b0; i_address = '0; d_req = 1'b1; d_write = 1'b1;
    d_address = 32'h0000_0040; d_byteenable = 4'hF; d_writedata = 32'h1;
    mem_readdata = '0; mem_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset strobes", 32'({mem_read, mem_write, i_ack, d_ack}), 32'd0);
    chk("reset mem_address", mem_address, 32'd0);
    chk("reset rdata", i_rdata | d_rdata, 32'd0);
    d_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Both requesters held: expect D,D,D,D,I cadence.
    reset_n = 1'b0; #1;
    reset_n = 1'b1;
    i_req = 1'b1; i_address = 32'h0000_0100;
    d_req = 1'b1; d_write = 1'b0; d_address = 32'h0000_0200; d_byteenable = 4'hF;
    mem_readdata = 32'h55AA_55AA; mem_waitrequest = 1'b0;
    overlap = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if ((i_ack && d_ack) || (mem_read && mem_write)) overlap++;
      if (i_ack || d_ack) begin
        ack_cyc.push_back(c);
        ack_is_i.push_back(i_ack);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("streak overlap", 32'(overlap), 32'd0);
    chk("streak enough acks", 32'(ack_cyc.size() >= 10), 32'd1);
    for (int j = 0; j < 10 && j < ack_cyc.size(); j++) begin
      chk($sformatf("streak grant%0d is_i", j), 32'(ack_is_i[j]), 32'((j % 5) == 4));
      if (j > 0) chk($sformatf("streak spacing%0d", j), 32'(ack_cyc[j] - ack_cyc[j-1]), 32'd3);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a stalled store.
    d_req = 1'b1; d_write = 1'b1; d_address = 32'h0000_4000; d_byteenable = 4'hF;
    d_writedata = 32'h1111_2222; mem_waitrequest = 1'b1;
    @(posedge clk); #1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst pre mem_write", 32'(mem_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst strobes", 32'({mem_read, mem_write, i_ack, d_ack}), 32'd0);
    chk("midrst mem_address", mem_address, 32'd0);
    chk("midrst mem_writedata", mem_writedata, 32'd0);
    chk("midrst mem_byteenable", 32'(mem_byteenable), 32'd0);
    chk("midrst d_rdata", d_rdata, 32'd0);
    chk("midrst i_rdata", i_rdata, 32'd0);
    d_req = 1'b0; mem_waitrequest = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    n_str = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (i_ack || d_ack || mem_read || mem_write) n_str++;
    end
    chk("midrst no activity after", 32'(n_str), 32'd0);

    // Load whose requester drops d_req right after the grant.
    @(posedge clk); #1;
    d_req = 1'b1; d_write = 1'b0; d_address = 32'h0000_5000; d_byteenable = 4'h1;
    d_writedata = '0; mem_readdata = 32'h0BAD_F00D; mem_waitrequest = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b0;
    n_rd = 0; n_dack = 0; n_iack = 0;
    for (int c = 0; c < 12; c++) begin
      mem_waitrequest = (c < 2);
      @(negedge clk);
      if (mem_read) n_rd++;
      if (d_ack) n_dack++;
      if (i_ack) n_iack++;
      @(posedge clk); #1;
    end
    chk("drop mem_read cycles", 32'(n_rd), 32'd3);
    chk("drop d_ack count", 32'(n_dack), 32'd1);
    chk("drop i_ack count", 32'(n_iack), 32'd0);
    chk("drop d_rdata", d_rdata, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
